// File: rtl/ed_alif_step_scheduler_if.sv
// rtl/ed_alif_step_scheduler_if.sv - Event-arbiter and neuron-step bundle for ed_alif_step_scheduler.
interface ed_alif_step_scheduler_if #(
  parameter int NREQ     = 4,
  parameter int V_WIDTH  = 12,
  parameter int RC_WIDTH = 4
);
  logic                        tick;
  logic [RC_WIDTH-1:0]         cfg_refract;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ*V_WIDTH-1:0]     req_weight;
  logic [NREQ-1:0]             req_ready;
  logic                        nrn_enable;
  logic signed [V_WIDTH-1:0]   nrn_I_syn;
  logic                        nrn_input_event;
  logic [RC_WIDTH-1:0]         nrn_refract_cnt;
  logic                        nrn_spike;
  logic                        spike_out;
  logic                        busy;
  logic                        tick_overrun;

  modport master (
    output tick, cfg_refract, req_valid, req_weight, nrn_spike,
    input  req_ready, nrn_enable, nrn_I_syn, nrn_input_event, nrn_refract_cnt,
           spike_out, busy, tick_overrun
  );

  modport slave (
    input  tick, cfg_refract, req_valid, req_weight, nrn_spike,
    output req_ready, nrn_enable, nrn_I_syn, nrn_input_event, nrn_refract_cnt,
           spike_out, busy, tick_overrun
  );
endinterface

// File: rtl/ed_alif_step_scheduler.sv
// rtl/ed_alif_step_scheduler.sv - Round-robin event accumulator and timestep sequencer for one ALIF neuron.
module ed_alif_step_scheduler #(
  parameter int NREQ     = 4,
  parameter int V_WIDTH  = 12,
  parameter int RC_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ed_alif_step_scheduler_if.slave  sched_if
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic signed [V_WIDTH-1:0] SAT_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] SAT_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_CHECK} state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic signed [V_WIDTH-1:0]  acc_q, acc_d;
  logic                       evt_q, evt_d;
  logic [RC_WIDTH-1:0]        refract_q, refract_d;
  logic signed [V_WIDTH-1:0]  isyn_q, isyn_d;
  logic                       in_evt_q, in_evt_d;
  logic [RC_WIDTH-1:0]        rc_out_q, rc_out_d;
  logic                       spike_q, spike_d;
  logic                       ovr_q, ovr_d;

  logic [NREQ-1:0]            grant;
  logic [PTR_W-1:0]           grant_idx;
  logic                       grant_any;
  logic signed [V_WIDTH-1:0]  grant_w;
  logic [V_WIDTH:0]           acc_sum;
  logic signed [V_WIDTH-1:0]  acc_sat;
  int                         arb_idx;

  // Scan requesters starting at rr_ptr; only the first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    grant_w   = '0;
    arb_idx   = 0;
    if (state_q == S_IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        arb_idx = int'(rr_ptr_q) + k;
        if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
        if (!grant_any && sched_if.req_valid[arb_idx]) begin
          grant_any      = 1'b1;
          grant[arb_idx] = 1'b1;
          grant_idx      = PTR_W'(arb_idx);
          grant_w        = sched_if.req_weight[arb_idx*V_WIDTH +: V_WIDTH];
        end
      end
    end
  end

  // grant_w is zero without a grant, so acc_sat doubles as the plain accumulator value.
  always_comb begin
    acc_sum = {acc_q[V_WIDTH-1], acc_q} + {grant_w[V_WIDTH-1], grant_w};
    if (acc_sum[V_WIDTH] != acc_sum[V_WIDTH-1])
      acc_sat = acc_sum[V_WIDTH] ? SAT_MIN : SAT_MAX;
    else
      acc_sat = acc_sum[V_WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    acc_d     = acc_q;
    evt_d     = evt_q;
    refract_d = refract_q;
    isyn_d    = isyn_q;
    in_evt_d  = in_evt_q;
    rc_out_d  = rc_out_q;
    spike_d   = 1'b0;
    ovr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          rr_ptr_d = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);
          acc_d    = acc_sat;
          evt_d    = 1'b1;
        end
        if (sched_if.tick) begin
          state_d  = S_STEP;
          isyn_d   = acc_sat;
          in_evt_d = evt_q | grant_any;
          rc_out_d = refract_q;
          acc_d    = '0;
          evt_d    = 1'b0;
        end
      end
      S_STEP: begin
        state_d = S_CHECK;
        ovr_d   = sched_if.tick;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        ovr_d   = sched_if.tick;
        if (sched_if.nrn_spike) begin
          refract_d = sched_if.cfg_refract;
          spike_d   = 1'b1;
        end else if (refract_q != '0) begin
          refract_d = refract_q - RC_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      acc_q     <= '0;
      evt_q     <= 1'b0;
      refract_q <= '0;
      isyn_q    <= '0;
      in_evt_q  <= 1'b0;
      rc_out_q  <= '0;
      spike_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      acc_q     <= acc_d;
      evt_q     <= evt_d;
      refract_q <= refract_d;
      isyn_q    <= isyn_d;
      in_evt_q  <= in_evt_d;
      rc_out_q  <= rc_out_d;
      spike_q   <= spike_d;
      ovr_q     <= ovr_d;
    end
  end

  // Gate grants with reset so requesters see no handshake while the block is held in reset.
  assign sched_if.req_ready       = grant & {NREQ{rst_n}};
  assign sched_if.nrn_enable      = (state_q == S_STEP);
  assign sched_if.busy            = (state_q != S_IDLE);
  assign sched_if.nrn_I_syn       = isyn_q;
  assign sched_if.nrn_input_event = in_evt_q;
  assign sched_if.nrn_refract_cnt = rc_out_q;
  assign sched_if.spike_out       = spike_q;
  assign sched_if.tick_overrun    = ovr_q;
endmodule

// File: tb/tb_ed_alif_step_scheduler.sv
// tb/tb_ed_alif_step_scheduler.sv - Directed and randomized checks of ed_alif_step_scheduler.
module tb_ed_alif_step_scheduler;
  localparam int N = 4;
  localparam int V = 12;
  localparam int R = 4;
  localparam int VMAX = 2047;
  localparam int VMIN = -2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  ed_alif_step_scheduler_if #(.NREQ(N), .V_WIDTH(V), .RC_WIDTH(R)) bus();

  ed_alif_step_scheduler #(.NREQ(N), .V_WIDTH(V), .RC_WIDTH(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.tick        = 1'b0;
    bus.req_valid   = '0;
    bus.req_weight  = '0;
    bus.nrn_spike   = 1'b0;
    bus.cfg_refract = '0;
  endtask

  task automatic set_req(input int i, input int w);
    bus.req_valid[i]          = 1'b1;
    bus.req_weight[i*V +: V]  = V'(w);
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    clk1();
    clk1();
    rst_n = 1'b1;
  endtask

  // Pulse one tick from IDLE and follow the step; returns values shown during enable.
  task automatic run_step(output int isyn, output logic evt, output int rc, output int en_cnt);
    isyn = 0; evt = 1'b0; rc = 0; en_cnt = 0;
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.nrn_enable) begin
        en_cnt++;
        isyn = int'($signed(bus.nrn_I_syn));
        evt  = bus.nrn_input_event;
        rc   = int'(bus.nrn_refract_cnt);
      end
      if (c < 2) clk1();
    end
  endtask

  task automatic test_reset();
    int isyn, rc, en;
    logic evt;
    clr_inputs();
    bus.req_valid = '1;
    rst_n = 1'b0;
    clk1();
    clk1();
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b want=0000", bus.req_ready); end
    total++; if ({bus.nrn_enable, bus.busy, bus.spike_out, bus.tick_overrun} !== 4'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=0000", {bus.nrn_enable, bus.busy, bus.spike_out, bus.tick_overrun}); end
    total++; if (bus.nrn_I_syn !== '0) begin bad++; $display("FAIL rst_isyn got=%0d want=0", bus.nrn_I_syn); end
    bus.req_valid = '0;
    rst_n = 1'b1;
    clk1();
    set_req(0, 300);
    clk1();
    bus.req_valid = '0;
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
    bus.req_valid = 4'b0011;
    total++; if ({bus.nrn_enable, bus.busy} !== 2'b11) begin bad++; $display("FAIL midstep_pre got=%b want=11", {bus.nrn_enable, bus.busy}); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.nrn_enable, bus.busy, bus.spike_out} !== 3'b0) begin bad++; $display("FAIL midstep_rst got=%b want=000", {bus.nrn_enable, bus.busy, bus.spike_out}); end
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL midstep_ready got=%b want=0000", bus.req_ready); end
    clk1();
    bus.req_valid = '0;
    rst_n = 1'b1;
    clk1();
    run_step(isyn, evt, rc, en);
    total++; if (en !== 1 || isyn !== 0 || evt !== 1'b0) begin bad++; $display("FAIL post_rst_step got=en%0d/%0d/%b want=en1/0/0", en, isyn, evt); end
  endtask

  task automatic test_accumulate();
    int isyn, rc, en;
    logic evt;
    do_reset();
    set_req(0, 20);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL acc_grant0 got=%b want=0001", bus.req_ready); end
    clk1();
    bus.req_valid = '0;
    set_req(1, 30);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL acc_grant1 got=%b want=0010", bus.req_ready); end
    clk1();
    bus.req_valid = '0;
    run_step(isyn, evt, rc, en);
    total++; if (en !== 1 || isyn !== 50 || evt !== 1'b1) begin bad++; $display("FAIL acc_step got=en%0d/%0d/%b want=en1/50/1", en, isyn, evt); end
    run_step(isyn, evt, rc, en);
    total++; if (en !== 1 || isyn !== 0 || evt !== 1'b0) begin bad++; $display("FAIL acc_cleared got=en%0d/%0d/%b want=en1/0/0", en, isyn, evt); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      exp = '0;
      exp[i % N] = 1'b1;
      #1;
      total++; if (bus.req_ready !== exp) begin bad++; $display("FAIL rr_cycle%0d got=%b want=%b", i, bus.req_ready, exp); end
      clk1();
    end
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL rr_only2 got=%b want=0100", bus.req_ready); end
    clk1();
    bus.req_valid = '1;
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
    total++; if (bus.req_ready !== 4'b0 || bus.nrn_enable !== 1'b1) begin bad++; $display("FAIL rr_step_noready got=%b/%b want=0000/1", bus.req_ready, bus.nrn_enable); end
    clk1();
    total++; if (bus.req_ready !== 4'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL rr_check_noready got=%b/%b want=0000/1", bus.req_ready, bus.busy); end
    bus.req_valid = '0;
    clk1();
  endtask

  task automatic test_saturation();
    int isyn, rc, en;
    logic evt;
    do_reset();
    set_req(0, 2000);
    repeat (3) clk1();
    bus.req_valid = '0;
    run_step(isyn, evt, rc, en);
    total++; if (isyn !== VMAX || evt !== 1'b1) begin bad++; $display("FAIL sat_pos got=%0d/%b want=%0d/1", isyn, evt, VMAX); end
    set_req(0, -2000);
    repeat (3) clk1();
    bus.req_valid = '0;
    run_step(isyn, evt, rc, en);
    total++; if (isyn !== VMIN || evt !== 1'b1) begin bad++; $display("FAIL sat_neg got=%0d/%b want=%0d/1", isyn, evt, VMIN); end
  endtask

  task automatic test_refractory();
    int isyn, rc, en;
    logic evt;
    do_reset();
    bus.cfg_refract = 4'd3;
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
    total++; if (bus.spike_out !== 1'b0 || bus.nrn_refract_cnt !== 4'd0) begin bad++; $display("FAIL ref_t1 got=%b/%0d want=0/0", bus.spike_out, bus.nrn_refract_cnt); end
    clk1();
    bus.nrn_spike = 1'b1;
    total++; if (bus.spike_out !== 1'b0) begin bad++; $display("FAIL ref_t2 got=%b want=0", bus.spike_out); end
    clk1();
    bus.nrn_spike = 1'b0;
    total++; if (bus.spike_out !== 1'b1) begin bad++; $display("FAIL ref_t3_spike got=%b want=1", bus.spike_out); end
    clk1();
    total++; if (bus.spike_out !== 1'b0) begin bad++; $display("FAIL ref_t4 got=%b want=0", bus.spike_out); end
    for (int k = 3; k >= 0; k--) begin
      run_step(isyn, evt, rc, en);
      total++; if (rc !== k || en !== 1) begin bad++; $display("FAIL ref_count got=%0d/en%0d want=%0d/en1", rc, en, k); end
    end
  endtask

  task automatic test_overrun();
    int en_seen;
    do_reset();
    bus.tick = 1'b1;
    clk1();
    en_seen = int'(bus.nrn_enable);
    total++; if (bus.tick_overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b want=0", bus.tick_overrun); end
    clk1();
    bus.tick = 1'b0;
    en_seen += int'(bus.nrn_enable);
    total++; if (bus.tick_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", bus.tick_overrun); end
    clk1();
    en_seen += int'(bus.nrn_enable);
    total++; if (bus.tick_overrun !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ovr_after got=%b/%b want=0/0", bus.tick_overrun, bus.busy); end
    clk1();
    en_seen += int'(bus.nrn_enable);
    total++; if (en_seen !== 1) begin bad++; $display("FAIL ovr_single_en got=%0d want=1", en_seen); end
    set_req(0, 10);
    clk1();
    bus.req_valid = '0;
    set_req(1, 7);
    bus.tick = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL coll_ready got=%b want=0010", bus.req_ready); end
    clk1();
    bus.tick = 1'b0;
    bus.req_valid = '0;
    total++; if (bus.nrn_enable !== 1'b1 || int'($signed(bus.nrn_I_syn)) !== 17 || bus.nrn_input_event !== 1'b1) begin bad++; $display("FAIL coll_step got=%b/%0d/%b want=1/17/1", bus.nrn_enable, $signed(bus.nrn_I_syn), bus.nrn_input_event); end
    clk1();
    clk1();
  endtask

  // Reference: a step occupies the two cycles after an accepted tick; events only land while not stepping.
  task automatic test_random();
    int phase, ptr, acc, refract, g, idx, isyn_e, rc_e;
    logic evt, evt_e, spk_e, ovr_e, tick_r, spike_r;
    logic [R-1:0] cfg_r;
    logic [N-1:0] vld, exp_ready;
    int wts [N];
    do_reset();
    phase = 0; ptr = 0; acc = 0; refract = 0; evt = 1'b0;
    isyn_e = 0; evt_e = 1'b0; rc_e = 0; vld = '0;
    for (int i = 0; i < N; i++) wts[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick_r  = ($urandom_range(0, 4) == 0);
      spike_r = ($urandom_range(0, 2) == 0);
      cfg_r   = R'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          wts[i] = int'($urandom_range(0, 3000)) - 1500;
        end
      end
      bus.tick = tick_r;
      bus.nrn_spike = spike_r;
      bus.cfg_refract = cfg_r;
      bus.req_valid = vld;
      for (int i = 0; i < N; i++) bus.req_weight[i*V +: V] = V'(wts[i]);
      #1;
      g = -1;
      if (phase == 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (g < 0 && vld[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      total++; if (bus.req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc%0d got=%b want=%b", cyc, bus.req_ready, exp_ready); end
      @(posedge clk);
      ovr_e = tick_r && (phase != 0);
      spk_e = (phase == 2) && spike_r;
      if (phase == 0) begin
        if (g >= 0) begin
          acc = sat(acc + wts[g]);
          evt = 1'b1;
          ptr = (g + 1) % N;
          vld[g] = 1'b0;
        end
        if (tick_r) begin
          isyn_e = acc; evt_e = evt; rc_e = refract;
          acc = 0; evt = 1'b0;
          phase = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else begin
        if (spike_r) refract = int'(cfg_r);
        else if (refract > 0) refract--;
        phase = 0;
      end
      #1;
      total++; if (bus.nrn_enable !== (phase == 1) || bus.busy !== (phase != 0)) begin bad++; $display("FAIL rnd_state cyc%0d got=en%b/busy%b want=phase%0d", cyc, bus.nrn_enable, bus.busy, phase); end
      total++; if (bus.spike_out !== spk_e || bus.tick_overrun !== ovr_e) begin bad++; $display("FAIL rnd_pulse cyc%0d got=%b/%b want=%b/%b", cyc, bus.spike_out, bus.tick_overrun, spk_e, ovr_e); end
      if (phase == 1) begin
        total++;
        if (int'($signed(bus.nrn_I_syn)) !== isyn_e || bus.nrn_input_event !== evt_e || int'(bus.nrn_refract_cnt) !== rc_e) begin
          bad++;
          $display("FAIL rnd_step cyc%0d got=%0d/%b/%0d want=%0d/%b/%0d", cyc, $signed(bus.nrn_I_syn), bus.nrn_input_event, bus.nrn_refract_cnt, isyn_e, evt_e, rc_e);
        end
      end
    end
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_round_robin();
    test_saturation();
    test_refractory();
    test_overrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
